// File: rtl/reg_cmd_ctrl.sv
// reg_cmd_ctrl: turns the UART byte stream into register-file commands.
//   Write frame: WR_CMD, address, data  -> one-cycle RF_WrEn
//   Read frame : RD_CMD, address        -> one-cycle RF_RdEn, then the
//                returned byte is pushed once into the TX FIFO.
// Ports:
//   CLK, RST (async, active-low)
//   RX_P_DATA / RX_D_VLD / RX_ERR         : received byte stream
//   RF_WrEn / RF_RdEn / RF_Address /
//   RF_WrData / RF_RdData / RF_RdData_Valid: register-file side
//   FIFO_WR_DATA / FIFO_WR_INC / FIFO_FULL : TX FIFO write port
//   BUSY     : FSM not idle
//   CMD_DROP : one-cycle pulse per discarded byte or aborted frame
// All outputs come straight from flops.
module reg_cmd_ctrl #(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    ADDRESS_WIDTH = 4,
  parameter logic [DATA_WIDTH-1:0] WR_CMD        = 8'hAA,
  parameter logic [DATA_WIDTH-1:0] RD_CMD        = 8'hBB
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  input  logic                     RX_ERR,
  output logic                     RF_WrEn,
  output logic                     RF_RdEn,
  output logic [ADDRESS_WIDTH-1:0] RF_Address,
  output logic [DATA_WIDTH-1:0]    RF_WrData,
  input  logic [DATA_WIDTH-1:0]    RF_RdData,
  input  logic                     RF_RdData_Valid,
  output logic [DATA_WIDTH-1:0]    FIFO_WR_DATA,
  output logic                     FIFO_WR_INC,
  input  logic                     FIFO_FULL,
  output logic                     BUSY,
  output logic                     CMD_DROP
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_ADDR  = 3'd1,
    WR_DATA  = 3'd2,
    WR_ISSUE = 3'd3,
    RD_ADDR  = 3'd4,
    RD_ISSUE = 3'd5,
    RD_WAIT  = 3'd6,
    TX_SEND  = 3'd7
  } state_t;

  state_t                   state_r, state_s;
  logic [ADDRESS_WIDTH-1:0] addr_hold_r, addr_hold_s;
  logic [ADDRESS_WIDTH-1:0] rf_addr_r, rf_addr_s;
  logic [DATA_WIDTH-1:0]    rf_wrdata_r, rf_wrdata_s;
  logic [DATA_WIDTH-1:0]    fifo_data_r, fifo_data_s;
  logic                     rf_wren_r, rf_wren_s;
  logic                     rf_rden_r, rf_rden_s;
  logic                     fifo_inc_r, fifo_inc_s;
  logic                     busy_r, busy_s;
  logic                     drop_r, drop_s;

  // Next-state and next-output logic; outputs are computed one cycle ahead
  // so that every strobe lands in the cycle its state is entered.
  always_comb begin
    state_s     = state_r;
    addr_hold_s = addr_hold_r;
    rf_addr_s   = rf_addr_r;
    rf_wrdata_s = rf_wrdata_r;
    fifo_data_s = fifo_data_r;
    rf_wren_s   = 1'b0;
    rf_rden_s   = 1'b0;
    fifo_inc_s  = 1'b0;
    drop_s      = 1'b0;

    if (RX_D_VLD && RX_ERR) begin
      // A corrupted byte kills whatever frame was being assembled.
      state_s = IDLE;
      drop_s  = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (RX_D_VLD) begin
            if (RX_P_DATA == WR_CMD) begin
              state_s = WR_ADDR;
            end else if (RX_P_DATA == RD_CMD) begin
              state_s = RD_ADDR;
            end else begin
              drop_s = 1'b1;
            end
          end else begin
            state_s = IDLE;
          end
        end
        WR_ADDR: begin
          if (RX_D_VLD) begin
            addr_hold_s = RX_P_DATA[ADDRESS_WIDTH-1:0];
            state_s     = WR_DATA;
          end else begin
            state_s = WR_ADDR;
          end
        end
        WR_DATA: begin
          // Address/data outputs only move when a command is issued, so an
          // aborted frame leaves the register-file bus untouched.
          if (RX_D_VLD) begin
            rf_addr_s   = addr_hold_r;
            rf_wrdata_s = RX_P_DATA;
            rf_wren_s   = 1'b1;
            state_s     = WR_ISSUE;
          end else begin
            state_s = WR_DATA;
          end
        end
        WR_ISSUE: begin
          drop_s  = RX_D_VLD;
          state_s = IDLE;
        end
        RD_ADDR: begin
          if (RX_D_VLD) begin
            rf_addr_s = RX_P_DATA[ADDRESS_WIDTH-1:0];
            rf_rden_s = 1'b1;
            state_s   = RD_ISSUE;
          end else begin
            state_s = RD_ADDR;
          end
        end
        RD_ISSUE: begin
          drop_s  = RX_D_VLD;
          state_s = RD_WAIT;
        end
        RD_WAIT: begin
          drop_s = RX_D_VLD;
          if (RF_RdData_Valid) begin
            fifo_data_s = RF_RdData;
            fifo_inc_s  = ~FIFO_FULL;
            state_s     = TX_SEND;
          end else begin
            state_s = RD_WAIT;
          end
        end
        TX_SEND: begin
          // fifo_inc_r high means the push is on the port this cycle.
          drop_s = RX_D_VLD;
          if (fifo_inc_r) begin
            state_s = IDLE;
          end else if (!FIFO_FULL) begin
            fifo_inc_s = 1'b1;
          end else begin
            state_s = TX_SEND;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end

    busy_s = (state_s != IDLE);
  end

  // State and output registers.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_r     <= IDLE;
      addr_hold_r <= {ADDRESS_WIDTH{1'b0}};
      rf_addr_r   <= {ADDRESS_WIDTH{1'b0}};
      rf_wrdata_r <= {DATA_WIDTH{1'b0}};
      fifo_data_r <= {DATA_WIDTH{1'b0}};
      rf_wren_r   <= 1'b0;
      rf_rden_r   <= 1'b0;
      fifo_inc_r  <= 1'b0;
      busy_r      <= 1'b0;
      drop_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      addr_hold_r <= addr_hold_s;
      rf_addr_r   <= rf_addr_s;
      rf_wrdata_r <= rf_wrdata_s;
      fifo_data_r <= fifo_data_s;
      rf_wren_r   <= rf_wren_s;
      rf_rden_r   <= rf_rden_s;
      fifo_inc_r  <= fifo_inc_s;
      busy_r      <= busy_s;
      drop_r      <= drop_s;
    end
  end

  assign RF_WrEn      = rf_wren_r;
  assign RF_RdEn      = rf_rden_r;
  assign RF_Address   = rf_addr_r;
  assign RF_WrData    = rf_wrdata_r;
  assign FIFO_WR_DATA = fifo_data_r;
  assign FIFO_WR_INC  = fifo_inc_r;
  assign BUSY         = busy_r;
  assign CMD_DROP     = drop_r;

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
module tb_reg_cmd_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] RX_P_DATA = 8'h00;
  logic       RX_D_VLD = 1'b0;
  logic       RX_ERR = 1'b0;
  logic       RF_WrEn, RF_RdEn;
  logic [3:0] RF_Address;
  logic [7:0] RF_WrData;
  logic [7:0] RF_RdData = 8'h00;
  logic       RF_RdData_Valid = 1'b0;
  logic [7:0] FIFO_WR_DATA;
  logic       FIFO_WR_INC;
  logic       FIFO_FULL = 1'b0;
  logic       BUSY, CMD_DROP;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int rd_cnt = 0;
  int push_cnt = 0;
  int drop_cnt = 0;

  // scoreboard: {addr, data} for writes, data for FIFO pushes
  logic [11:0] exp_wr[$];
  logic [7:0]  exp_push[$];

  reg_cmd_ctrl dut (
    .CLK(CLK), .RST(RST),
    .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD), .RX_ERR(RX_ERR),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
    .RF_WrData(RF_WrData), .RF_RdData(RF_RdData), .RF_RdData_Valid(RF_RdData_Valid),
    .FIFO_WR_DATA(FIFO_WR_DATA), .FIFO_WR_INC(FIFO_WR_INC), .FIFO_FULL(FIFO_FULL),
    .BUSY(BUSY), .CMD_DROP(CMD_DROP)
  );

  always #5 CLK = ~CLK;

  // monitor: pops scoreboard on every strobe, counts events
  always @(negedge CLK) begin
    if (RF_WrEn) begin
      wr_cnt++;
      checks++;
      if (exp_wr.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected: got addr=%h data=%h, none expected", RF_Address, RF_WrData);
      end else begin
        logic [11:0] e;
        e = exp_wr.pop_front();
        if ({RF_Address, RF_WrData} !== e) begin
          errors++;
          $display("FAIL wr_value: got %h expected %h", {RF_Address, RF_WrData}, e);
        end
      end
      if (RF_RdEn) begin
        errors++;
        $display("FAIL wr_rd_overlap: got both strobes high, expected exclusive");
      end
    end
    if (RF_RdEn) rd_cnt++;
    if (FIFO_WR_INC) begin
      push_cnt++;
      checks++;
      if (exp_push.size() == 0) begin
        errors++;
        $display("FAIL push_unexpected: got data=%h, none expected", FIFO_WR_DATA);
      end else begin
        logic [7:0] p;
        p = exp_push.pop_front();
        if (FIFO_WR_DATA !== p) begin
          errors++;
          $display("FAIL push_value: got %h expected %h", FIFO_WR_DATA, p);
        end
      end
    end
    if (CMD_DROP) drop_cnt++;
  end

  // presents one byte for one cycle; entered and left #1 after a rising edge
  task automatic send_byte(input logic [7:0] b, input logic err);
    RX_P_DATA = b;
    RX_D_VLD  = 1'b1;
    RX_ERR    = err;
    @(posedge CLK); #1;
    RX_D_VLD  = 1'b0;
    RX_ERR    = 1'b0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({RF_WrEn, RF_RdEn, RF_Address, RF_WrData, FIFO_WR_DATA, FIFO_WR_INC, BUSY, CMD_DROP} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {RF_WrEn, RF_RdEn, RF_Address, RF_WrData, FIFO_WR_DATA, FIFO_WR_INC, BUSY, CMD_DROP});
    end
  endtask

  task automatic test_write(input logic [7:0] a, input logic [7:0] d);
    int w0;
    w0 = wr_cnt;
    exp_wr.push_back({a[3:0], d});
    send_byte(8'hAA, 1'b0);
    send_byte(a, 1'b0);
    send_byte(d, 1'b0);
    // cycle N+1
    checks++;
    if ({RF_WrEn, RF_Address, RF_WrData, BUSY} !== {1'b1, a[3:0], d, 1'b1}) begin
      errors++;
      $display("FAIL write_n1: got en=%b addr=%h data=%h busy=%b expected en=1 addr=%h data=%h busy=1",
               RF_WrEn, RF_Address, RF_WrData, BUSY, a[3:0], d);
    end
    step(1);
    // cycle N+2
    checks++;
    if ({RF_WrEn, BUSY} !== 2'b00) begin
      errors++;
      $display("FAIL write_n2: got en=%b busy=%b expected 0 0", RF_WrEn, BUSY);
    end
    checks++;
    if (wr_cnt - w0 !== 1) begin
      errors++;
      $display("FAIL write_count: got %0d expected 1", wr_cnt - w0);
    end
  endtask

  task automatic test_read;
    exp_push.push_back(8'h5A);
    send_byte(8'hBB, 1'b0);
    send_byte(8'h02, 1'b0);
    checks++;
    if ({RF_RdEn, RF_WrEn, RF_Address} !== {1'b1, 1'b0, 4'h2}) begin
      errors++;
      $display("FAIL read_n1: got rd=%b wr=%b addr=%h expected rd=1 wr=0 addr=2", RF_RdEn, RF_WrEn, RF_Address);
    end
    step(1);
    // N+2: register file answers
    RF_RdData = 8'h5A;
    RF_RdData_Valid = 1'b1;
    checks++;
    if ({RF_RdEn, FIFO_WR_INC} !== 2'b00) begin
      errors++;
      $display("FAIL read_n2: got rd=%b push=%b expected 0 0", RF_RdEn, FIFO_WR_INC);
    end
    step(1);
    RF_RdData_Valid = 1'b0;
    checks++;
    if ({FIFO_WR_INC, FIFO_WR_DATA} !== {1'b1, 8'h5A}) begin
      errors++;
      $display("FAIL read_n3: got push=%b data=%h expected push=1 data=5a", FIFO_WR_INC, FIFO_WR_DATA);
    end
    step(1);
    checks++;
    if ({FIFO_WR_INC, BUSY} !== 2'b00) begin
      errors++;
      $display("FAIL read_n4: got push=%b busy=%b expected 0 0", FIFO_WR_INC, BUSY);
    end
  endtask

  task automatic test_backpressure;
    int p0;
    p0 = push_cnt;
    exp_push.push_back(8'hC3);
    FIFO_FULL = 1'b1;
    send_byte(8'hBB, 1'b0);
    send_byte(8'h03, 1'b0);
    step(1);
    RF_RdData = 8'hC3;
    RF_RdData_Valid = 1'b1;
    step(1);
    RF_RdData_Valid = 1'b0;
    step(9);
    checks++;
    if (push_cnt - p0 !== 0 || FIFO_WR_INC !== 1'b0 || BUSY !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold: got pushes=%0d inc=%b busy=%b expected 0 0 1", push_cnt - p0, FIFO_WR_INC, BUSY);
    end
    FIFO_FULL = 1'b0;
    checks++;
    if (FIFO_WR_INC !== 1'b0) begin
      errors++;
      $display("FAIL bp_release_same_cycle: got inc=%b expected 0", FIFO_WR_INC);
    end
    step(1);
    checks++;
    if ({FIFO_WR_INC, FIFO_WR_DATA} !== {1'b1, 8'hC3}) begin
      errors++;
      $display("FAIL bp_push: got inc=%b data=%h expected 1 c3", FIFO_WR_INC, FIFO_WR_DATA);
    end
    step(4);
    checks++;
    if (push_cnt - p0 !== 1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL bp_once: got pushes=%0d busy=%b expected 1 0", push_cnt - p0, BUSY);
    end
  endtask

  task automatic test_junk;
    int d0, w0;
    d0 = drop_cnt;
    w0 = wr_cnt + rd_cnt;
    send_byte(8'h7E, 1'b0);
    checks++;
    if ({CMD_DROP, BUSY, RF_WrEn, RF_RdEn} !== 4'b1000) begin
      errors++;
      $display("FAIL junk: got drop=%b busy=%b wr=%b rd=%b expected 1 0 0 0", CMD_DROP, BUSY, RF_WrEn, RF_RdEn);
    end
    step(2);
    checks++;
    if (drop_cnt - d0 !== 1 || wr_cnt + rd_cnt !== w0) begin
      errors++;
      $display("FAIL junk_count: got drops=%0d strobes=%0d expected 1 0", drop_cnt - d0, wr_cnt + rd_cnt - w0);
    end
  endtask

  task automatic test_rx_err;
    int w0;
    w0 = wr_cnt;
    send_byte(8'hAA, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h3C, 1'b1);
    checks++;
    if ({CMD_DROP, BUSY, RF_WrEn} !== 3'b100) begin
      errors++;
      $display("FAIL rx_err: got drop=%b busy=%b wr=%b expected 1 0 0", CMD_DROP, BUSY, RF_WrEn);
    end
    // a new opcode is accepted straight away
    test_write(8'h06, 8'h77);
    checks++;
    if (wr_cnt - w0 !== 1) begin
      errors++;
      $display("FAIL rx_err_count: got writes=%0d expected 1", wr_cnt - w0);
    end
  endtask

  task automatic test_overrun;
    int d0, p0;
    d0 = drop_cnt;
    p0 = push_cnt;
    exp_push.push_back(8'h44);
    FIFO_FULL = 1'b1;
    send_byte(8'hBB, 1'b0);
    send_byte(8'h04, 1'b0);
    step(1);                       // RD_WAIT, no data yet
    send_byte(8'h11, 1'b0);
    RF_RdData = 8'h44;
    RF_RdData_Valid = 1'b1;
    send_byte(8'h22, 1'b0);        // still RD_WAIT, data captured
    RF_RdData_Valid = 1'b0;
    send_byte(8'h33, 1'b0);        // TX_SEND
    FIFO_FULL = 1'b0;
    step(5);
    checks++;
    if (drop_cnt - d0 !== 3) begin
      errors++;
      $display("FAIL overrun_drops: got %0d expected 3", drop_cnt - d0);
    end
    checks++;
    if (push_cnt - p0 !== 1 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL overrun_push: got pushes=%0d busy=%b expected 1 0", push_cnt - p0, BUSY);
    end
  endtask

  task automatic test_back_to_back;
    exp_wr.push_back({4'hA, 8'h55});
    exp_wr.push_back({4'hB, 8'h66});
    send_byte(8'hAA, 1'b0);
    send_byte(8'h0A, 1'b0);
    send_byte(8'h55, 1'b0);
    step(1);                       // back in IDLE
    send_byte(8'hAA, 1'b0);
    send_byte(8'h0B, 1'b0);
    send_byte(8'h66, 1'b0);
    checks++;
    if ({RF_WrEn, RF_Address, RF_WrData} !== {1'b1, 4'hB, 8'h66}) begin
      errors++;
      $display("FAIL b2b: got en=%b addr=%h data=%h expected 1 b 66", RF_WrEn, RF_Address, RF_WrData);
    end
    step(2);
  endtask

  task automatic test_reset_midframe;
    int w0, d0;
    send_byte(8'hAA, 1'b0);
    send_byte(8'h05, 1'b0);
    checks++;
    if (BUSY !== 1'b1) begin
      errors++;
      $display("FAIL midframe_busy: got %b expected 1", BUSY);
    end
    RST = 1'b0;
    #1;
    checks++;
    if ({RF_WrEn, RF_RdEn, RF_Address, RF_WrData, FIFO_WR_DATA, FIFO_WR_INC, BUSY, CMD_DROP} !== 27'd0) begin
      errors++;
      $display("FAIL midframe_reset: got %h expected 0",
               {RF_WrEn, RF_RdEn, RF_Address, RF_WrData, FIFO_WR_DATA, FIFO_WR_INC, BUSY, CMD_DROP});
    end
    @(negedge CLK);
    RST = 1'b1;
    step(1);
    w0 = wr_cnt;
    d0 = drop_cnt;
    send_byte(8'h07, 1'b0);
    send_byte(8'h11, 1'b0);
    step(3);
    checks++;
    if (wr_cnt !== w0 || drop_cnt - d0 !== 2 || BUSY !== 1'b0) begin
      errors++;
      $display("FAIL midframe_after: got writes=%0d drops=%0d busy=%b expected 0 2 0",
               wr_cnt - w0, drop_cnt - d0, BUSY);
    end
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    test_reset;
    @(negedge CLK);
    RST = 1'b1;
    step(1);
    test_write(8'h05, 8'h3C);
    test_write(8'hF9, 8'h81);      // upper address bits ignored
    test_read;
    test_backpressure;
    test_junk;
    test_rx_err;
    test_overrun;
    test_back_to_back;
    test_reset_midframe;
    checks++;
    if (exp_wr.size() != 0 || exp_push.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover: got wr=%0d push=%0d expected 0 0", exp_wr.size(), exp_push.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_cmd_ctrl.md
# reg_cmd_ctrl

Command controller between the UART receiver and the register file. It parses received byte streams into register-file write and read commands and drives the register file's write/read strobes, address and write data. For reads, it forwards the read byte to the transmit FIFO write port. It sits in the reference-clock domain, directly upstream of the register file and of the TX FIFO.

## Interface
- DATA_WIDTH, 8, byte width of RX data, register data and FIFO data
- ADDRESS_WIDTH, 4, register-file address width
- WR_CMD, 8'hAA, opcode for a register write (frame: opcode, address, data)
- RD_CMD, 8'hBB, opcode for a register read (frame: opcode, address)

- CLK  in  1  reference clock
- RST  in  1  asynchronous, active-low reset
- RX_P_DATA  in  DATA_WIDTH  received byte, valid when RX_D_VLD=1
- RX_D_VLD  in  1  one-cycle pulse per received byte, already synchronous to CLK
- RX_ERR  in  1  parity/stop error flag qualifying the current RX byte
- RF_WrEn  out  1  register-file write strobe
- RF_RdEn  out  1  register-file read strobe
- RF_Address  out  ADDRESS_WIDTH  register-file address
- RF_WrData  out  DATA_WIDTH  register-file write data
- RF_RdData  in  DATA_WIDTH  register-file read data
- RF_RdData_Valid  in  1  register-file read-data valid
- FIFO_WR_DATA  out  DATA_WIDTH  byte for the TX FIFO
- FIFO_WR_INC  out  1  one-cycle TX FIFO push
- FIFO_FULL  in  1  TX FIFO full
- BUSY  out  1  high whenever the FSM is not in IDLE
- CMD_DROP  out  1  one-cycle pulse per discarded byte or aborted frame

## Operation
- All outputs are registered. Reset drives every output to 0 and the FSM to IDLE.
- FSM states: IDLE, WR_ADDR, WR_DATA, WR_ISSUE, RD_ADDR, RD_ISSUE, RD_WAIT, TX_SEND.
- IDLE transitions on an RX byte:
  - WR_CMD goes to WR_ADDR.
  - RD_CMD goes to RD_ADDR.
  - Any other value stays in IDLE and pulses CMD_DROP.
- WR_ADDR: the next byte's low ADDRESS_WIDTH bits are latched as the address; upper bits are ignored. Next state is WR_DATA.
- WR_DATA: the next byte is latched as write data. Next state is WR_ISSUE.
- WR_ISSUE: RF_WrEn=1 for exactly one cycle with RF_Address and RF_WrData stable. Next state is IDLE.
- RD_ADDR: latch the address from the next byte. Next state is RD_ISSUE.
- RD_ISSUE: RF_RdEn=1 for exactly one cycle. Next state is RD_WAIT.
- RD_WAIT:
  - If RF_RdData_Valid=1, capture RF_RdData into the TX holding register and go to TX_SEND.
  - Otherwise, remain in RD_WAIT.
- TX_SEND:
  - If FIFO_FULL=0, assert FIFO_WR_INC for one cycle with FIFO_WR_DATA set to the held byte, then go to IDLE.
  - If FIFO_FULL=1, hold with no push.
- RF_WrEn and RF_RdEn are never high in the same cycle.
- RF_Address and RF_WrData hold their last value between commands.
- RX_ERR=1 with RX_D_VLD in any state:
  - Discard the byte and any partial frame.
  - Pulse CMD_DROP and return to IDLE. The next cycle accepts a new opcode.
- A byte arriving in WR_ISSUE, RD_ISSUE, RD_WAIT or TX_SEND is discarded and CMD_DROP pulses. The in-progress command completes normally.
- CMD_DROP pulses at most once per cycle.

## Timing
- Latencies are counted from the cycle the final byte is presented with RX_D_VLD=1 (cycle N).
- Write: RF_WrEn is high in cycle N+1.
- Read:
  - RF_RdEn is high in cycle N+1.
  - RF_RdData is sampled in RD_WAIT in cycle N+2.
  - FIFO_WR_INC is high in cycle N+3 if the FIFO is not full.
  - With FIFO_FULL, FIFO_WR_INC is delayed until the first cycle after FIFO_FULL deasserts. Exactly one push occurs.
- The minimum gap back to IDLE is 1 cycle after a write strobe and 1 cycle after a FIFO push.
- Back-to-back RX_D_VLD on consecutive cycles is accepted while in IDLE, WR_ADDR, WR_DATA and RD_ADDR.
- Reset asserted mid-frame:
  - The FSM goes to IDLE immediately (asynchronously) and all outputs clear.
  - A pending TX byte is lost.
  - No RF strobe or FIFO push occurs after reset release until a new full frame is received.

## Test plan
- Write: bytes AA, 05, 3C → RF_WrEn=1 for one cycle at N+1 with RF_Address=5 and RF_WrData=3C. BUSY returns to 0 at N+2.
- Read: RF_RdData=5A, bytes BB, 02 → RF_RdEn at N+1, then FIFO_WR_INC with FIFO_WR_DATA=5A at N+3.
- FIFO backpressure: read while FIFO_FULL=1 for 10 cycles → no push until FIFO_FULL=0, then exactly one FIFO_WR_INC.
- Errors and junk:
  - Byte 7E in IDLE → CMD_DROP pulse, no RF strobe.
  - AA, 05, then a data byte with RX_ERR=1 → CMD_DROP pulse, no RF_WrEn, FSM in IDLE.
- Overrun: bytes arriving during RD_WAIT/TX_SEND → one CMD_DROP pulse per byte, read response still pushed once.
- Reset mid-frame: assert RST after AA, 05 → all outputs 0. Then send 07, 11 → no write occurs (07 is dropped as an unknown opcode).
